vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the VGA output path; sits directly downstream of the pixel PLL.
//  Runs on the PLL output clock and is held idle until the PLL reports lock.
//  Produces HSYNC/VSYNC, a data-enable flag, pixel X/Y coordinates and a frame-start strobe.
//  These outputs drive the pixel-colour stage and the VGA pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    HSYNC asserted level (0 = active-low)
//  VS_POL    0    VSYNC asserted level (0 = active-low)
//  CW        10   width of the counters and of PIX_X/PIX_Y; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  CLK          in   1   pixel clock from the PLL
//  RST_N        in   1   asynchronous reset, active-low
//  LOCKED       in   1   PLL lock; level, synchronous to CLK
//  HSYNC        out  1   horizontal sync, registered
//  VSYNC        out  1   vertical sync, registered
//  DE           out  1   high while the pixel is inside the visible area
//  PIX_X        out  CW  column of the current pixel; valid when DE=1
//  PIX_Y        out  CW  line of the current pixel; valid when DE=1
//  FRAME_START  out  1   one-cycle pulse coincident with pixel (0,0)
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
//  - Reset (RST_N=0, asynchronous):
//    - h_cnt = v_cnt = 0.
//    - HSYNC = ~HS_POL and VSYNC = ~VS_POL (the deasserted levels).
//    - DE = 0, PIX_X = PIX_Y = 0, FRAME_START = 0.
//  - LOCKED=0 (synchronous effect): counters are forced to 0 and outputs hold their reset values.
//    - A loss of lock mid-frame aborts the frame.
//    - The first cycle with LOCKED=1 uses count (0,0).
//  - Horizontal counter h_cnt counts 0..H_TOTAL-1 once per CLK, then wraps to 0.
//  - Vertical counter v_cnt advances only on the cycle where h_cnt wraps; it wraps 0 after V_TOTAL-1.
//    - At the end of the frame (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1), both wrap on the same edge.
//  - Phases per axis, decoded from the counter (no separate state register): ACTIVE, FP, SYNC, BP.
//    - H: ACTIVE [0,640), FP [640,656), SYNC [656,752), BP [752,800).
//    - V: the same pattern in lines.
//  - All outputs are registered. Latency is exactly 1 CLK: outputs after edge n describe the count held before edge n.
//    - DE = (h in ACTIVE) && (v in ACTIVE).
//    - PIX_X = h_cnt and PIX_Y = v_cnt when DE is high; both read 0 when DE is low.
//    - HSYNC = HS_POL when h is in SYNC, ~HS_POL otherwise.
//    - VSYNC = VS_POL when v is in SYNC, ~VS_POL otherwise.
//    - VSYNC changes only on the same edge where HSYNC changes for h_cnt = 0 (line-aligned).
//    - FRAME_START = 1 for exactly one cycle, when the output count is (0,0); this includes the first count after lock.
//  - No back-pressure: downstream stages must accept one pixel per CLK while DE=1.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - default 640x480@60 porch/sync constants;
//    - H_TOTAL/V_TOTAL derivation functions;
//    - the phase enum typedef {ACTIVE, FP, SYNC, BP}.
//  - One sub-module, vga_axis_counter (params ACTIVE/FP/SYNC/BP, CW), instantiated twice:
//    - inputs: clk, rst_n, clr, en;
//    - outputs: cnt, wrap (comb), phase.
//    - Horizontal instance: en = 1.
//    - Vertical instance: en = h wrap.
//  - Top level: clr = ~LOCKED, plus the output register stage.
// TESTING
//  1. Reset, then LOCKED held 0 for 100 CLK -> HSYNC=1, VSYNC=1, DE=0, FRAME_START=0 throughout.
//  2. LOCKED rises -> FRAME_START=1 exactly one CLK later with DE=1, PIX_X=0, PIX_Y=0; then PIX_X=1 on the next CLK.
//  3. One full line -> DE high for 640 consecutive CLK; HSYNC low 96 CLK starting 656 CLK after DE rises; period 800 CLK.
//  4. One full frame -> 480 lines with DE; VSYNC low for 2x800 CLK starting at line 490; FRAME_START period 420000 CLK.
//  5. Drop LOCKED at PIX_X=300, PIX_Y=200 for 5 CLK, then restore -> outputs idle within 1 CLK; FRAME_START reasserts 1 CLK after relock.
//  6. Assert RST_N=0 asynchronously mid-line (between edges) -> outputs reach reset values immediately, before the next CLK edge.
//  7. Run with HS_POL=1 and VS_POL=1 -> sync levels are inverted and the timing is identical to scenarios 3 and 4.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants, axis-total helpers and the per-axis phase type
// for the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int h_active, input int h_fp, input int h_sync, input int h_bp);
        return axis_total(h_active, h_fp, h_sync, h_bp);
    endfunction

    function automatic int v_total(input int v_active, input int v_fp, input int v_sync, input int v_bp);
        return axis_total(v_active, v_fp, v_sync, v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with its phase decoded
// combinationally from the count, so no separate phase state is kept.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap,
    output phase_e        o_phase
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FP_START = CW'(ACTIVE);
    localparam logic [CW-1:0] SY_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BP_START = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    // Wrap is only meaningful while the axis is enabled and not being cleared.
    assign o_wrap = i_en && !i_clr && w_last;
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_phase = PH_ACTIVE;
        if (r_cnt >= BP_START) begin
            o_phase = PH_BP;
        end else if (r_cnt >= SY_START) begin
            o_phase = PH_SYNC;
        end else if (r_cnt >= FP_START) begin
            o_phase = PH_FP;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters held clear until PLL lock,
// followed by a single register stage for sync, data-enable, coordinates and frame start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_locked,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_pix_x,
    output logic [CW-1:0] o_pix_y,
    output logic          o_frame_start
);

    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    phase_e        w_h_phase;
    phase_e        w_v_phase;
    logic          w_clr;
    logic          w_de;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_pix_x;
    logic [CW-1:0] r_pix_y;
    logic          r_frame_start;

    assign w_clr = ~i_locked;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (1'b1),
        .o_cnt   (w_h_cnt),
        .o_wrap  (w_h_wrap),
        .o_phase (w_h_phase)
    );

    // The vertical axis steps once per line, so VSYNC is inherently line-aligned.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_h_wrap),
        .o_cnt   (w_v_cnt),
        .o_wrap  (w_v_wrap),
        .o_phase (w_v_phase)
    );

    assign w_de = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
        end else if (!i_locked) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            r_vsync       <= (w_v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_pix_x       <= w_de ? w_h_cnt : '0;
            r_pix_y       <= w_de ? w_v_cnt : '0;
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_frame_start = r_frame_start;

    // End-of-frame wrap is implied by both counters returning to zero together.
    logic w_unused;
    assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance plus two small-raster
// instances (active-low and active-high sync) driven from the same clock, reset and lock.
module tb_vga_timing_gen;

    localparam int CW = 10;

    logic clk;
    logic rst_n;
    logic locked;

    logic          d0_hs, d0_vs, d0_de, d0_fs;
    logic [CW-1:0] d0_x, d0_y;
    logic          d1_hs, d1_vs, d1_de, d1_fs;
    logic [CW-1:0] d1_x, d1_y;
    logic          d2_hs, d2_vs, d2_de, d2_fs;
    logic [CW-1:0] d2_x, d2_y;

    vga_timing_gen #(.CW(CW)) dut_full (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked),
        .o_hsync(d0_hs), .o_vsync(d0_vs), .o_de(d0_de),
        .o_pix_x(d0_x), .o_pix_y(d0_y), .o_frame_start(d0_fs)
    );

    // Small raster: H 8/2/3/2 (15 total), V 4/1/2/1 (8 lines), 120 clocks per frame.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked),
        .o_hsync(d1_hs), .o_vsync(d1_vs), .o_de(d1_de),
        .o_pix_x(d1_x), .o_pix_y(d1_y), .o_frame_start(d1_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut_small_inv (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked),
        .o_hsync(d2_hs), .o_vsync(d2_vs), .o_de(d2_de),
        .o_pix_x(d2_x), .o_pix_y(d2_y), .o_frame_start(d2_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Packed view: {hs, vs, de, fs, x[9:0], y[9:0]}
    function automatic logic [23:0] pk(input logic hs, input logic vs, input logic de,
                                       input logic fs, input int x, input int y);
        return {hs, vs, de, fs, 10'(x), 10'(y)};
    endfunction

    function automatic logic [23:0] snap(input int d);
        case (d)
            0:       return {d0_hs, d0_vs, d0_de, d0_fs, d0_x, d0_y};
            1:       return {d1_hs, d1_vs, d1_de, d1_fs, d1_x, d1_y};
            default: return {d2_hs, d2_vs, d2_de, d2_fs, d2_x, d2_y};
        endcase
    endfunction

    function automatic logic [23:0] idle_val(input int d);
        return (d == 2) ? pk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0) : pk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    endfunction

    // Reference raster: expected outputs for the n-th count after lock.
    function automatic logic [23:0] model(input int d, input int n);
        int ha, hf, hs, hb, va, vf, vs, vb, ht, vt, h, v;
        logic pol, de, hsy, vsy, fs;
        if (d == 0) begin
            ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0;
        end else begin
            ha = 8; hf = 2; hs = 3; hb = 2; va = 4; vf = 1; vs = 2; vb = 1; pol = (d == 2);
        end
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        h   = n % ht;
        v   = (n / ht) % vt;
        de  = (h < ha) && (v < va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        fs  = (h == 0) && (v == 0);
        return pk(hsy, vsy, de, fs, de ? h : 0, de ? v : 0);
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got hs=%0b vs=%0b de=%0b fs=%0b x=%0d y=%0d, required hs=%0b vs=%0b de=%0b fs=%0b x=%0d y=%0d",
                     name, act[23], act[22], act[21], act[20], act[19:10], act[9:0],
                     exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_all(input string name);
        for (int d = 0; d < 3; d++) chk($sformatf("%s_dut%0d", name, d), snap(d), idle_val(d));
    endtask

    typedef struct {
        int          dut;
        int          n;
        logic [23:0] exp;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        int   hits, fs0_cnt, fs1_cnt, de0_cnt, hs0_low, hs2_high;
        bit   found;
        logic [23:0] s;

        // Hand-computed checkpoints (n = count index since lock)
        tbl[0]  = '{0, 0,    pk(1, 1, 1, 1, 0,   0)};
        tbl[1]  = '{0, 1,    pk(1, 1, 1, 0, 1,   0)};
        tbl[2]  = '{0, 639,  pk(1, 1, 1, 0, 639, 0)};
        tbl[3]  = '{0, 640,  pk(1, 1, 0, 0, 0,   0)};
        tbl[4]  = '{0, 655,  pk(1, 1, 0, 0, 0,   0)};
        tbl[5]  = '{0, 656,  pk(0, 1, 0, 0, 0,   0)};
        tbl[6]  = '{0, 751,  pk(0, 1, 0, 0, 0,   0)};
        tbl[7]  = '{0, 752,  pk(1, 1, 0, 0, 0,   0)};
        tbl[8]  = '{0, 799,  pk(1, 1, 0, 0, 0,   0)};
        tbl[9]  = '{0, 800,  pk(1, 1, 1, 0, 0,   1)};
        tbl[10] = '{0, 1439, pk(1, 1, 1, 0, 639, 1)};
        tbl[11] = '{0, 1456, pk(0, 1, 0, 0, 0,   0)};
        tbl[12] = '{0, 2000, pk(1, 1, 1, 0, 400, 2)};
        tbl[13] = '{1, 10,   pk(0, 1, 0, 0, 0,   0)};
        tbl[14] = '{1, 13,   pk(1, 1, 0, 0, 0,   0)};
        tbl[15] = '{1, 52,   pk(1, 1, 1, 0, 7,   3)};
        tbl[16] = '{1, 74,   pk(1, 1, 0, 0, 0,   0)};
        tbl[17] = '{1, 75,   pk(1, 0, 0, 0, 0,   0)};
        tbl[18] = '{1, 104,  pk(1, 0, 0, 0, 0,   0)};
        tbl[19] = '{1, 105,  pk(1, 1, 0, 0, 0,   0)};
        tbl[20] = '{1, 120,  pk(1, 1, 1, 1, 0,   0)};
        tbl[21] = '{2, 0,    pk(0, 0, 1, 1, 0,   0)};
        tbl[22] = '{2, 10,   pk(1, 0, 0, 0, 0,   0)};
        tbl[23] = '{2, 75,   pk(0, 1, 0, 0, 0,   0)};
        tbl[24] = '{2, 119,  pk(0, 0, 0, 0, 0,   0)};

        rst_n  = 1'b0;
        locked = 1'b0;
        #12;
        chk_idle_all("reset");

        // Locked low after reset release: everything idle
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                s = snap(d);
                if (s !== idle_val(d)) chk($sformatf("unlocked_c%0d_dut%0d", i, d), s, idle_val(d));
            end
        end
        chk_idle_all("unlocked_end");

        // Lock and run 2400 counts; full-size covers 3 lines, small covers 20 frames
        @(negedge clk);
        locked   = 1'b1;
        hits     = 0;
        fs0_cnt  = 0;
        fs1_cnt  = 0;
        de0_cnt  = 0;
        hs0_low  = 0;
        hs2_high = 0;
        for (int n = 0; n < 2400; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) chk($sformatf("run_n%0d_dut%0d", n, d), snap(d), model(d, n));
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].n == n) begin
                    chk($sformatf("vec%0d_n%0d", i, n), snap(tbl[i].dut), tbl[i].exp);
                    hits++;
                end
            end
            fs0_cnt  += int'(d0_fs);
            fs1_cnt  += int'(d1_fs);
            de0_cnt  += int'(d0_de);
            hs0_low  += int'(!d0_hs);
            hs2_high += int'(d2_hs);
        end
        chk_int("table_hits", hits, NV);
        chk_int("full_fs_pulses", fs0_cnt, 1);
        chk_int("small_fs_pulses", fs1_cnt, 20);
        chk_int("full_de_cycles_3lines", de0_cnt, 3 * 640);
        chk_int("full_hsync_low_3lines", hs0_low, 3 * 96);
        chk_int("inv_hsync_high_160lines", hs2_high, 160 * 3);

        // Lock loss mid-frame on the small raster at pixel (3,2)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (d1_de && d1_x == 10'd3 && d1_y == 10'd2) found = 1'b1;
        end
        chk_int("wait_x3_y2", int'(found), 1);
        @(negedge clk);
        locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_idle_all($sformatf("lockloss_c%0d", i));
        end
        @(negedge clk);
        locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) chk($sformatf("relock_c%0d_dut%0d", i, d), snap(d), model(d, i));
        end

        // Asynchronous reset between edges while the full raster is on pixel (2,0)
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("post_reset_dut%0d", d), snap(d), model(d, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
